// File: rtl/obc1_responder.sv
// obc1_responder: OBC1 coprocessor responder. Translates SNES accesses in the
// OBC1 window onto a single-port 8 KiB work RAM, keeps the shadowed status
// (base select) and index registers, and sequences reads and writes.
// Optional feature macro: OBC1_HITABLE_EN enables the $7FF4 high-table address
// translation and read-modify-write merge. Without it, $1FF4 is a plain byte.
module obc1_responder #(
    parameter logic [12:0] OBJ_BASE_0 = 13'h1C00,
    parameter logic [12:0] OBJ_BASE_1 = 13'h1800
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        obc1_enable,
    input  logic [12:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        rd_strobe,
    input  logic        wr_strobe,
    output logic [7:0]  SNES_DATA_OUT,
    output logic        data_valid,
    output logic        busy,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    // WR is the single cycle in which a plain write drives ram_we.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3
`ifdef OBC1_HITABLE_EN
        ,
        RMW_ADDR  = 3'd4,
        RMW_DATA  = 3'd5,
        RMW_WRITE = 3'd6
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        status;
    logic [6:0]  index;
    logic [12:0] base;
    logic [12:0] xlat_addr;
    logic        accept_wr;
    logic        accept_rd;

    // Strobes are only taken in IDLE; a simultaneous write wins over a read.
    assign accept_wr = (state == IDLE) && wr_strobe && obc1_enable;
    assign accept_rd = (state == IDLE) && rd_strobe && obc1_enable && !wr_strobe;
    assign busy      = (state != IDLE);

`ifdef OBC1_HITABLE_EN
    logic       is_hi;
    logic [2:0] hi_shift;
    logic [7:0] merged;

    assign is_hi    = (SNES_ADDR == 13'h1FF4);
    // Each high-table byte packs four 2-bit fields; index[1:0] picks one.
    assign hi_shift = {index[1:0], 1'b0};
    assign merged   = (ram_dout & ~(8'h03 << hi_shift))
                    | ({6'b0, ram_din[1:0]} << hi_shift);
    assign ram_we   = (state == WR) || (state == RMW_WRITE);
`else
    assign ram_we   = (state == WR);
`endif

    // Translate the SNES offset to a work RAM address using the current shadows.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        base      = status ? OBJ_BASE_1 : OBJ_BASE_0;
        xlat_addr = SNES_ADDR;
        if (SNES_ADDR[12:2] == 11'h7FC)
            xlat_addr = base + {4'b0, index, SNES_ADDR[1:0]};
`ifdef OBC1_HITABLE_EN
        else if (is_hi)
            xlat_addr = base + 13'h200 + {8'b0, index[6:2]};
`endif
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: accept in IDLE, then walk the fixed access sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_wr) begin
`ifdef OBC1_HITABLE_EN
                    state_next = is_hi ? RMW_ADDR : WR;
`else
                    state_next = WR;
`endif
                end else if (accept_rd) begin
                    state_next = RD_ADDR;
                end
            end
            WR:        state_next = IDLE;
            RD_ADDR:   state_next = RD_DATA;
            RD_DATA:   state_next = IDLE;
`ifdef OBC1_HITABLE_EN
            RMW_ADDR:  state_next = RMW_DATA;
            RMW_DATA:  state_next = RMW_WRITE;
            RMW_WRITE: state_next = IDLE;
`endif
            default:   state_next = IDLE;
        endcase
    end

    // Datapath: latch address/data at the strobe, shadow updates, read capture, merge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            status        <= 1'b0;
            index         <= 7'd0;
            ram_addr      <= 13'd0;
            ram_din       <= 8'h00;
            SNES_DATA_OUT <= 8'h00;
            data_valid    <= 1'b0;
        end else begin
            data_valid <= (state == RD_DATA);
            if (state == RD_DATA)
                SNES_DATA_OUT <= ram_dout;
            if (accept_wr || accept_rd)
                ram_addr <= xlat_addr;
            if (accept_wr) begin
                ram_din <= SNES_DATA_IN;
                if (SNES_ADDR == 13'h1FF5) status <= SNES_DATA_IN[0];
                if (SNES_ADDR == 13'h1FF6) index  <= SNES_DATA_IN[6:0];
            end
`ifdef OBC1_HITABLE_EN
            if (state == RMW_DATA)
                ram_din <= merged;
`endif
        end
    end

endmodule
